// File: rtl/pwd_candidate_gen.sv
// Purpose : sweeps every fixed-width decimal password "0..0".."9..9" as ASCII,
//           LANES candidates per cycle, lane i always holding values == i (mod LANES).
// Latency : one cycle from start / accepted advance to the new candidate set; outputs registered.
// Backpr. : advances only when i_ready=1 and i_stop=0; i_stop freezes the set and ends the sweep.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             begin a fresh sweep (honoured in IDLE/DONE only)
//   i_stop              halt sweep, freeze presented candidates (honoured in RUN only)
//   i_ready             downstream accepts the current candidate set
//   o_cand              lane i at [i*8*DIGITS +: 8*DIGITS], leftmost char in top byte
//   o_lane_valid        per-lane in-range flag
//   o_cand_valid        candidate set valid (RUN)
//   o_busy              sweep in progress
//   o_exhausted         sweep ended by running out of values
//   o_stopped           sweep ended by stop request
//   o_attempts          accepted-candidate count (needs CANDGEN_ATTEMPT_CNT_EN, else 0)
//
// Optional feature macro: CANDGEN_ATTEMPT_CNT_EN enables the saturating attempts counter.

module pwd_candidate_gen #(
    parameter int LANES  = 3,
    parameter int DIGITS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_ready,
    output logic [LANES*8*DIGITS-1:0] o_cand,
    output logic [LANES-1:0]          o_lane_valid,
    output logic                      o_cand_valid,
    output logic                      o_busy,
    output logic                      o_exhausted,
    output logic                      o_stopped,
    output logic [31:0]               o_attempts
);

    localparam int W = 8 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [LANES*W-1:0]      r_cand;
    logic [LANES-1:0]        r_lane_valid;
    logic                    r_cand_valid;
    logic                    r_busy;
    logic                    r_exhausted;
    logic                    r_stopped;

    logic [LANES*W-1:0]      w_zero_cand;
    logic [LANES*W-1:0]      w_init_cand;
    logic [LANES*W-1:0]      w_next_cand;
    logic [LANES-1:0]        w_next_valid;
    logic                    w_advance;

    // Adds LANES to an ASCII decimal string. Digit 0 (lowest byte) is the
    // rightmost character; carry ripples toward the top byte. Result bit W
    // is the carry out of the leftmost digit (lane overflow).
    function automatic logic [W:0] bcd_add(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [7:0]   s;
        logic         c;
        r = v;
        c = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            s = v[j*8 +: 8] - 8'h30 + {7'd0, c};
            if (j == 0) s = s + 8'(LANES);
            if (s >= 8'd10) begin
                c = 1'b1;
                s = s - 8'd10;
            end else begin
                c = 1'b0;
            end
            r[j*8 +: 8] = 8'h30 + s;
        end
        return {c, r};
    endfunction

    assign w_zero_cand = {(LANES*DIGITS){8'h30}};
    assign w_advance   = (r_state == S_RUN) && i_ready && !i_stop;

    // Fresh-sweep load: lane l starts at value l (always < 10^DIGITS as LANES <= 9).
    always_comb begin
        w_init_cand = w_zero_cand;
        for (int l = 0; l < LANES; l++) begin
            w_init_cand[l*W +: 8] = 8'h30 + 8'(l);
        end
    end

    // Invalid lanes are not advanced so their contents stay ASCII digits.
    always_comb begin
        logic [W:0] sum;
        w_next_cand  = r_cand;
        w_next_valid = r_lane_valid;
        sum          = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane_valid[l]) begin
                sum                  = bcd_add(r_cand[l*W +: W]);
                w_next_cand[l*W +: W] = sum[W-1:0];
                w_next_valid[l]       = !sum[W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cand       <= w_zero_cand;
            r_lane_valid <= '0;
            r_cand_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_exhausted  <= 1'b0;
            r_stopped    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state      <= S_RUN;
                        r_cand       <= w_init_cand;
                        r_lane_valid <= {LANES{1'b1}};
                        r_cand_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_exhausted  <= 1'b0;
                        r_stopped    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_stop) begin
                        // Candidates left untouched so the checker can read the hit.
                        r_state      <= S_DONE;
                        r_cand_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_stopped    <= 1'b1;
                    end else if (i_ready) begin
                        r_cand       <= w_next_cand;
                        r_lane_valid <= w_next_valid;
                        if (w_next_valid == '0) begin
                            r_state      <= S_DONE;
                            r_cand_valid <= 1'b0;
                            r_busy       <= 1'b0;
                            r_exhausted  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cand       <= w_zero_cand;
                    r_lane_valid <= '0;
                    r_cand_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_exhausted  <= 1'b0;
                    r_stopped    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CANDGEN_ATTEMPT_CNT_EN
    logic [31:0] r_attempts;
    logic [3:0]  w_pop;
    logic [32:0] w_att_sum;

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pop = w_pop + {3'd0, r_lane_valid[l]};
        end
    end

    assign w_att_sum = {1'b0, r_attempts} + {29'd0, w_pop};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_attempts <= '0;
        end else if ((r_state != S_RUN) && i_start) begin
            r_attempts <= '0;
        end else if (w_advance) begin
            r_attempts <= w_att_sum[32] ? 32'hFFFF_FFFF : w_att_sum[31:0];
        end
    end

    assign o_attempts = r_attempts;
`else
    assign o_attempts = 32'd0;
`endif

    assign o_cand       = r_cand;
    assign o_lane_valid = r_lane_valid;
    assign o_cand_valid = r_cand_valid;
    assign o_busy       = r_busy;
    assign o_exhausted  = r_exhausted;
    assign o_stopped    = r_stopped;

endmodule

// File: tb/tb_pwd_candidate_gen.sv
// Directed bench: LANES=3/DIGITS=8 instance for load, advance, carry, hold,
// stop and reset; LANES=3/DIGITS=2 instance for a full sweep to exhaustion.
module tb_pwd_candidate_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DIGITS=8 instance
    logic         a_reset, a_start, a_stop, a_ready;
    logic [191:0] a_cand;
    logic [2:0]   a_lv;
    logic         a_cv, a_busy, a_exh, a_stp;
    logic [31:0]  a_att;

    // DIGITS=2 instance
    logic         b_reset, b_start, b_stop, b_ready;
    logic [47:0]  b_cand;
    logic [2:0]   b_lv;
    logic         b_cv, b_busy, b_exh, b_stp;
    logic [31:0]  b_att;

    pwd_candidate_gen #(.LANES(3), .DIGITS(8)) dut8 (
        .i_clk(clk), .i_reset(a_reset), .i_start(a_start), .i_stop(a_stop),
        .i_ready(a_ready), .o_cand(a_cand), .o_lane_valid(a_lv),
        .o_cand_valid(a_cv), .o_busy(a_busy), .o_exhausted(a_exh),
        .o_stopped(a_stp), .o_attempts(a_att)
    );

    pwd_candidate_gen #(.LANES(3), .DIGITS(2)) dut2 (
        .i_clk(clk), .i_reset(b_reset), .i_start(b_start), .i_stop(b_stop),
        .i_ready(b_ready), .o_cand(b_cand), .o_lane_valid(b_lv),
        .o_cand_valid(b_cv), .o_busy(b_busy), .o_exhausted(b_exh),
        .o_stopped(b_stp), .o_attempts(b_att)
    );

    int checks = 0;
    int errors = 0;

`ifdef CANDGEN_ATTEMPT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Expected attempts value: the count when the counter is built, else 0.
    function automatic logic [31:0] att(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [63:0] dec8(input int v);
        logic [63:0] r;
        int x;
        x = v;
        for (int j = 0; j < 8; j++) begin
            r[j*8 +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] dec2(input int v);
        return {8'h30 + 8'((v / 10) % 10), 8'h30 + 8'(v % 10)};
    endfunction

    function automatic logic [191:0] set8(input int v0, input int v1, input int v2);
        return {dec8(v2), dec8(v1), dec8(v0)};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the DIGITS=8 instance status outputs in one go.
    task automatic chk_a(input string tag, input logic [191:0] cand, input logic [2:0] lv,
                         input logic cv, input logic busy, input logic exh,
                         input logic stp, input logic [31:0] at);
        chk({tag, ".cand"}, a_cand, cand);
        chk({tag, ".lane_valid"}, 192'(a_lv), 192'(lv));
        chk({tag, ".cand_valid"}, 192'(a_cv), 192'(cv));
        chk({tag, ".busy"}, 192'(a_busy), 192'(busy));
        chk({tag, ".exhausted"}, 192'(a_exh), 192'(exh));
        chk({tag, ".stopped"}, 192'(a_stp), 192'(stp));
        chk({tag, ".attempts"}, 192'(a_att), 192'(at));
    endtask

    initial begin
        a_reset = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b0;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;
        tick();
        chk_a("reset", set8(0, 0, 0), 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // stop in IDLE is ignored
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        chk_a("idle_stop", set8(0, 0, 0), 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // start -> first set 0/1/2
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_a("start", set8(0, 1, 2), 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

        a_ready = 1'b1;
        tick();
        chk_a("adv1", set8(3, 4, 5), 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, att(3));
        tick();
        chk_a("adv2", set8(6, 7, 8), 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, att(6));
        tick();
        chk("adv3.cand", a_cand, set8(9, 10, 11));
        tick();
        chk_a("carry", set8(12, 13, 14), 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, att(12));

        // ready low holds everything for 5 cycles
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.cand", a_cand, set8(12, 13, 14));
        end
        chk("hold.attempts", 192'(a_att), 192'(att(12)));

        // start in RUN ignored
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_a("run_start", set8(12, 13, 14), 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, att(12));

        // stop wins over ready; lane1 "00000013" stays visible
        a_stop = 1'b1;
        a_ready = 1'b1;
        tick();
        chk_a("stop", set8(12, 13, 14), 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, att(12));
        chk("stop.lane1", 192'(a_cand[64 +: 64]), 192'(dec8(13)));
        tick();
        a_stop = 1'b0;
        chk_a("done_hold", set8(12, 13, 14), 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, att(12));

        // restart from DONE: fresh sweep, flags cleared
        a_ready = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_a("restart", set8(0, 1, 2), 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

        // reset mid-sweep with ready high: no partial advance
        a_ready = 1'b1;
        tick();
        tick();
        chk("pre_reset.cand", a_cand, set8(6, 7, 8));
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_ready = 1'b0;
        chk_a("mid_reset", set8(0, 0, 0), 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // DIGITS=2 full sweep to exhaustion
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("d2.start.cand", 192'(b_cand), 192'({dec2(2), dec2(1), dec2(0)}));
        b_ready = 1'b1;
        for (int i = 0; i < 33; i++) tick();
        chk("d2.adv33.lane0", 192'(b_cand[15:0]), 192'(dec2(99)));
        chk("d2.adv33.lane_valid", 192'(b_lv), 192'(3'b001));
        chk("d2.adv33.cand_valid", 192'(b_cv), 192'(1'b1));
        chk("d2.adv33.attempts", 192'(b_att), 192'(att(99)));
        tick();
        chk("d2.exh.exhausted", 192'(b_exh), 192'(1'b1));
        chk("d2.exh.stopped", 192'(b_stp), 192'(1'b0));
        chk("d2.exh.cand_valid", 192'(b_cv), 192'(1'b0));
        chk("d2.exh.busy", 192'(b_busy), 192'(1'b0));
        chk("d2.exh.lane_valid", 192'(b_lv), 192'(3'b000));
        chk("d2.exh.attempts", 192'(b_att), 192'(att(100)));
        tick();
        chk("d2.done_hold.attempts", 192'(b_att), 192'(att(100)));
        chk("d2.done_hold.exhausted", 192'(b_exh), 192'(1'b1));
        b_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
